// File: rtl/nbody_host_if_if.sv
// Avalon-MM slave bus bundle between the HPS bridge and the n-body host front-end.
interface nbody_host_if_if #(
  parameter int BUS_W  = 32,
  parameter int ADDR_W = 16
);
  logic              chipselect;
  logic              write;
  logic              read;
  logic [ADDR_W-1:0] addr;
  logic [BUS_W-1:0]  writedata;
  logic [BUS_W-1:0]  readdata;
  logic              readdatavalid;

  modport master (
    output chipselect, write, read, addr, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  chipselect, write, read, addr, writedata,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/nbody_host_if.sv
// Host front-end for the n-body engine: 64-bit body upload/readback in bus-width
// halves with atomic assembly, plus the step sequencer (GO / GAP / READ lock / DONE).
module nbody_host_if #(
  parameter int BUS_W       = 32,
  parameter int ADDR_W      = 16,
  parameter int BODY_ADDR_W = 9,
  parameter int N_IN        = 5,
  parameter int N_OUT       = 2,
  parameter int FIELD_W     = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  nbody_host_if_if.slave         bus,
  output logic                   mem_we,
  output logic [FIELD_W-1:0]     mem_field,
  output logic [BODY_ADDR_W-1:0] mem_idx,
  output logic [2*BUS_W-1:0]     mem_wdata,
  output logic [FIELD_W-1:0]     rd_field,
  output logic [BODY_ADDR_W-1:0] rd_idx,
  input  logic [2*BUS_W-1:0]     rd_data,
  output logic [BODY_ADDR_W:0]   n_bodies,
  output logic                   step_start,
  input  logic                   step_done
);
  localparam int SEL_W = ADDR_W - BODY_ADDR_W;
  localparam int DW    = 2 * BUS_W;
  localparam logic [BODY_ADDR_W:0] MAX_BODIES = {1'b1, {BODY_ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, WAIT, HOLD} state_t;
  typedef enum logic [1:0] {RK_IMM, RK_LO, RK_HI_RAM, RK_HI_HOLD} rd_kind_t;

  state_t                 state;
  logic                   go, read_lock, done, wr_err, read_seen;
  logic [BUS_W-1:0]       gap, step_cnt;
  logic [BUS_W-1:0]       stage [N_IN];
  logic [BODY_ADDR_W-1:0] stage_idx [N_IN];
  logic [N_IN-1:0]        stage_vld;
  logic [DW-1:0]          hold;
  logic                   hold_vld;
  logic [FIELD_W-1:0]     hold_g, rd_field_q;
  logic [BODY_ADDR_W-1:0] hold_idx, rd_idx_q;
  logic                   s1_vld;
  rd_kind_t               s1_kind;
  logic [BUS_W-1:0]       s1_imm;

  logic [SEL_W-1:0]       sel, in_ofs, out_ofs;
  logic [BODY_ADDR_W-1:0] idx;
  logic [FIELD_W-1:0]     in_f, out_g;
  logic                   wr, rd, busy, in_hit, out_hit, field_wr, lo_wr, hi_wr;
  logic                   rd_lo, rd_hi, hi_match, ram_rd, status_rd, go_eff, err_set;
  logic                   stage_ok;
  logic [BUS_W-1:0]       stage_sel, status_word;

  assign sel     = bus.addr[ADDR_W-1:BODY_ADDR_W];
  assign idx     = bus.addr[BODY_ADDR_W-1:0];
  assign wr      = bus.chipselect & bus.write;
  assign rd      = bus.chipselect & bus.read;
  assign busy    = (state == RUN) || (state == WAIT);
  assign in_ofs  = sel - SEL_W'(4);
  assign out_ofs = sel - SEL_W'(65);
  assign in_f    = FIELD_W'(in_ofs >> 1);
  assign out_g   = FIELD_W'(out_ofs >> 1);
  assign in_hit  = (sel >= SEL_W'(4)) && (sel < SEL_W'(4 + 2*N_IN));
  assign out_hit = (sel >= SEL_W'(65)) && (sel < SEL_W'(65 + 2*N_OUT));

  assign field_wr  = wr && in_hit;
  assign lo_wr     = field_wr && !in_ofs[0];
  assign hi_wr     = field_wr && in_ofs[0];
  assign rd_lo     = rd && out_hit && !out_ofs[0];
  assign rd_hi     = rd && out_hit && out_ofs[0];
  assign hi_match  = hold_vld && (hold_g == out_g) && (hold_idx == idx);
  assign ram_rd    = rd_lo || (rd_hi && !hi_match);
  assign status_rd = rd && (sel == SEL_W'(64));
  assign go_eff    = (wr && sel == SEL_W'(0)) ? bus.writedata[0] : go;

  // The RAM address is presented combinationally during the strobe so rd_data
  // arrives one cycle later and readdata can meet the two-cycle read latency.
  assign rd_field = ram_rd ? out_g : rd_field_q;
  assign rd_idx   = ram_rd ? idx : rd_idx_q;

  assign status_word = BUS_W'({read_lock, wr_err, busy, done});

  assign err_set = (step_done && state != WAIT) || (field_wr && busy) ||
                   (hi_wr && !busy && !stage_ok) || (rd_hi && !hi_match);

  always_comb begin
    stage_sel = '0;
    stage_ok  = 1'b0;
    for (int f = 0; f < N_IN; f++) begin
      if (in_f == FIELD_W'(f)) begin
        stage_sel = stage[f];
        stage_ok  = stage_vld[f] && (stage_idx[f] == idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      go                <= 1'b0;
      read_lock         <= 1'b0;
      n_bodies          <= '0;
      gap               <= BUS_W'(1);
      wr_err            <= 1'b0;
      stage_vld         <= '0;
      for (int f = 0; f < N_IN; f++) begin
        stage[f]     <= '0;
        stage_idx[f] <= '0;
      end
      mem_we            <= 1'b0;
      mem_field         <= '0;
      mem_idx           <= '0;
      mem_wdata         <= '0;
      hold              <= '0;
      hold_vld          <= 1'b0;
      hold_g            <= '0;
      hold_idx          <= '0;
      rd_field_q        <= '0;
      rd_idx_q          <= '0;
      s1_vld            <= 1'b0;
      s1_kind           <= RK_IMM;
      s1_imm            <= '0;
      bus.readdata      <= '0;
      bus.readdatavalid <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (wr && sel == SEL_W'(0)) go <= bus.writedata[0];
      if (wr && sel == SEL_W'(1)) read_lock <= bus.writedata[0];
      if (wr && sel == SEL_W'(2))
        n_bodies <= (bus.writedata > BUS_W'(MAX_BODIES)) ? MAX_BODIES
                                                         : (BODY_ADDR_W+1)'(bus.writedata);
      if (wr && sel == SEL_W'(3))
        gap <= (bus.writedata == '0) ? BUS_W'(1) : bus.writedata;

      for (int f = 0; f < N_IN; f++) begin
        if (in_f == FIELD_W'(f) && !busy) begin
          if (lo_wr) begin
            stage[f]     <= bus.writedata;
            stage_idx[f] <= idx;
            stage_vld[f] <= 1'b1;
          end
          if (hi_wr) stage_vld[f] <= 1'b0;
        end
      end
      if (hi_wr && !busy) begin
        mem_we    <= 1'b1;
        mem_field <= in_f;
        mem_idx   <= idx;
        mem_wdata <= {bus.writedata, stage_sel};
      end

      // A concurrent error event wins over the clear-on-read of STATUS.
      wr_err <= (status_rd ? 1'b0 : wr_err) | err_set;

      s1_vld <= rd;
      s1_imm <= status_rd ? status_word : '0;
      if (rd_lo)                s1_kind <= RK_LO;
      else if (rd_hi && hi_match) s1_kind <= RK_HI_HOLD;
      else if (rd_hi)           s1_kind <= RK_HI_RAM;
      else                      s1_kind <= RK_IMM;
      if (ram_rd) begin
        rd_field_q <= out_g;
        rd_idx_q   <= idx;
        hold_vld   <= 1'b1;
        hold_g     <= out_g;
        hold_idx   <= idx;
      end

      bus.readdatavalid <= s1_vld;
      if (s1_vld) begin
        case (s1_kind)
          RK_LO: begin
            hold         <= rd_data;
            bus.readdata <= rd_data[BUS_W-1:0];
          end
          RK_HI_RAM: begin
            hold         <= rd_data;
            bus.readdata <= rd_data[DW-1:BUS_W];
          end
          RK_HI_HOLD: bus.readdata <= hold[DW-1:BUS_W];
          default:    bus.readdata <= s1_imm;
        endcase
      end
    end
  end

  // Step sequencer; HOLD waits for the host to raise and then drop READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      step_cnt   <= '0;
      done       <= 1'b0;
      read_seen  <= 1'b0;
      step_start <= 1'b0;
    end else begin
      step_start <= 1'b0;
      case (state)
        IDLE: if (go_eff && n_bodies != '0) begin
          state      <= RUN;
          step_start <= 1'b1;
        end
        RUN: state <= WAIT;
        WAIT: if (step_done) begin
          step_cnt <= step_cnt + BUS_W'(1);
          if (step_cnt + BUS_W'(1) == gap) begin
            done  <= 1'b1;
            state <= HOLD;
          end else if (go_eff) begin
            state      <= RUN;
            step_start <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        HOLD: begin
          if (read_seen && !read_lock) begin
            done      <= 1'b0;
            step_cnt  <= '0;
            read_seen <= 1'b0;
            if (go_eff) begin
              state      <= RUN;
              step_start <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (read_lock) begin
            read_seen <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
